cla_seq_adder: RTL and testbench
================================

// Module: cla_seq_adder
// PURPOSE
//  Multi-cycle WIDTH-bit add/subtract unit built from one shared 4-bit carry-lookahead slice.
//  The block sequences the slice over WIDTH/4 nibbles, LSB first, and holds the carry in a register between nibbles.
//  It serves low-area paths (address/offset and multiply-step adds) through a valid/ready request and response handshake.
// PARAMETERS
//  WIDTH  16  operand/result width; must be a multiple of 4 and >= 4
//  NIB    WIDTH/4 (derived localparam)  number of slice iterations
// PORTS
//  clk         in   1      clock; all state updates on the rising edge
//  rst_n       in   1      asynchronous active-low reset
//  req_valid   in   1      request present
//  req_ready   out  1      block can accept a request (IDLE only)
//  op_a        in   WIDTH  operand A, sampled at request handshake
//  op_b        in   WIDTH  operand B, sampled at request handshake
//  sub         in   1      1 = A-B, 0 = A+B; sampled at request handshake
//  flush       in   1      synchronous abort; returns the block to IDLE
//  resp_valid  out  1      result valid
//  resp_ready  in   1      consumer accepts the result
//  result      out  WIDTH  sum or difference
//  cout        out  1      carry out of the MSB (for sub: 1 = no borrow)
//  ovf         out  1      two's-complement signed overflow
//  zero        out  1      result == 0
// BEHAVIOUR
//  Reset: state=IDLE. req_ready=1; resp_valid, result, cout, ovf and zero all 0. nib_idx=0, carry reg=0.
//  FSM IDLE -> RUN on req_valid&req_ready.
//   - Latch op_a, and op_b (sub ? ~op_b : op_b).
//   - Carry reg <= sub. Latch the sign bits of A and of B-effective. nib_idx <= 0.
//  RUN: each cycle, feed slice with A[4i+:4], Beff[4i+:4] and the carry reg, where i=nib_idx.
//   - Write the slice sum into result[4i+:4]; carry reg <= slice carry out; nib_idx++.
//   - When nib_idx==NIB-1, go to DONE.
//  DONE: resp_valid=1. result/cout/ovf/zero stay stable until resp_valid&resp_ready, then go to IDLE.
//  Latency: resp_valid rises exactly NIB+1 cycles after the accepting edge (WIDTH=16 -> 5 cycles).
//  Throughput: 1 op per NIB+2 cycles minimum. No accept in DONE, even when resp_ready is high (no bypass).
//  cout = final carry reg. ovf = (signA==signBeff) & (result[WIDTH-1]!=signA). zero = ~|result.
//  All three are registered; valid in DONE only and held there.
//  The carry reg is WIDTH-independent (1 bit). nib_idx is $clog2(NIB) bits (min 1) and never wraps past NIB-1.
//  flush: any state -> IDLE next edge; resp_valid=0; a pending response is discarded.
//   - flush wins over req_valid and resp_ready in the same cycle.
//  req_valid while not in IDLE: ignored (req_ready=0); the requester holds operands until accepted.
//  Operands may change after acceptance without effect.
//  rst_n low mid-RUN/DONE: immediate async return to reset values; the partial result is lost, no response issued.
//  NIB==1: RUN lasts one cycle, then DONE.
// STRUCTURE
//  Shared package/header: state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2; WIDTH default 16.
//  Sub-module: one instance of cla4 (existing 4-bit CLA slice: inA, inB, cIn -> sum, c0).
//   - Slice is purely combinational; all sequencing, muxing and flags live in this block.
//  Nibble select = indexed part-select on latched operands; result write = per-nibble enable from nib_idx.
// TESTING
//  1) 0x1234 + 0x0FFF, sub=0 -> result 0x2233, cout 0, ovf 0, zero 0; resp_valid exactly 5 cycles after accept.
//  2) 0xFFFF + 0x0001 -> result 0x0000, cout 1, zero 1, ovf 0 (carry ripples through all 4 nibbles).
//  3) 0x8000 - 0x0001, sub=1 -> result 0x7FFF, cout 1, ovf 1. Also 0x0003 - 0x0005 -> 0xFFFE, cout 0, ovf 0.
//  4) resp_ready low 6 cycles in DONE -> outputs stable, req_ready 0, new req_valid ignored.
//   - Then resp_ready=1 -> IDLE; the next request is accepted the following cycle.
//  5) rst_n pulsed low in RUN at nib_idx=2 -> all outputs at reset values asynchronously; a fresh 0x0001+0x0001 gives 0x0002.
//  6) flush in RUN and again in DONE (with resp_ready=1 the same cycle) -> IDLE next cycle, no response handshake occurs.
//   - Repeat test 1 with WIDTH=4 and WIDTH=32 (random vs. reference model, 1000 ops).

Source files
------------

// File: rtl/cla_seq_adder_pkg.sv
// cla_seq_adder_pkg: state encoding and default width shared by the sequential adder
package cla_seq_adder_pkg;
  localparam int WIDTH_DEF = 16;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/cla_seq_adder_cla4.sv
// cla_seq_adder_cla4: purely combinational 4-bit carry-lookahead slice
module cla_seq_adder_cla4 (
  input  logic [3:0] inA,
  input  logic [3:0] inB,
  input  logic       cIn,
  output logic [3:0] sum,
  output logic       c0
);
  logic [3:0] g, p;
  logic [3:0] c;
  assign g = inA & inB;
  assign p = inA ^ inB;
  assign c[0] = cIn;
  assign c[1] = g[0] | (p[0] & cIn);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cIn);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cIn);
  assign c0   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cIn);
  assign sum  = p ^ c;
endmodule

// File: rtl/cla_seq_adder.sv
// cla_seq_adder: multi-cycle add/subtract sequencing one 4-bit CLA slice over the operand nibbles
module cla_seq_adder
  import cla_seq_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = NIB > 1 ? $clog2(NIB) : 1;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, result_q, result_d;
  logic [IW-1:0]    idx_q;
  logic             c_q, sa_q, sb_q, valid_q, cout_q, ovf_q, zero_q;
  logic [3:0]       slice_sum;
  logic             slice_co, last;

  cla_seq_adder_cla4 u_cla4 (
    .inA (a_q[{idx_q, 2'b00} +: 4]),
    .inB (b_q[{idx_q, 2'b00} +: 4]),
    .cIn (c_q),
    .sum (slice_sum),
    .c0  (slice_co)
  );

  assign last = idx_q == IW'(NIB - 1);

  always_comb begin
    result_d = result_q;
    result_d[{idx_q, 2'b00} +: 4] = slice_sum;
  end

  // b_q holds the effective operand (inverted for subtract) so the slice only ever adds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      idx_q    <= '0;
      c_q      <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      valid_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else if (flush) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (req_valid) begin
          a_q     <= op_a;
          b_q     <= sub ? ~op_b : op_b;
          c_q     <= sub;
          sa_q    <= op_a[WIDTH-1];
          sb_q    <= sub ^ op_b[WIDTH-1];
          idx_q   <= '0;
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          result_q <= result_d;
          c_q      <= slice_co;
          idx_q    <= last ? idx_q : idx_q + IW'(1);
          if (last) begin
            state_q <= ST_DONE;
            valid_q <= 1'b1;
            cout_q  <= slice_co;
            ovf_q   <= (sa_q == sb_q) & (result_d[WIDTH-1] != sa_q);
            zero_q  <= ~|result_d;
          end
        end
        ST_DONE: if (resp_ready) begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = state_q == ST_IDLE;
  assign resp_valid = valid_q;
  assign result     = result_q;
  assign cout       = cout_q;
  assign ovf        = ovf_q;
  assign zero       = zero_q;
endmodule

// File: tb/tb_cla_seq_adder.sv
// tb_cla_seq_adder: random and directed checks of 4/16/32-bit instances against an arithmetic model
module tb_cla_seq_adder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req_valid = '0, sub = '0, flush = '0, resp_ready = '1;
  logic [2:0]  req_ready, resp_valid, cout, ovf, zero;
  logic [31:0] op_a[3], op_b[3], res[3];
  logic [3:0]  r4;
  logic [15:0] r16;
  logic [31:0] r32;
  int          tests = 0, fails = 0;

  logic        pend[3];
  int          wt[3];
  logic [31:0] er[3];
  logic        ec[3], eo[3], ez[3];

  always #5 clk = ~clk;

  assign res[0] = {28'd0, r4};
  assign res[1] = {16'd0, r16};
  assign res[2] = r32;

  cla_seq_adder #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .op_a(op_a[0][3:0]), .op_b(op_b[0][3:0]), .sub(sub[0]), .flush(flush[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .result(r4),
    .cout(cout[0]), .ovf(ovf[0]), .zero(zero[0]));
  cla_seq_adder #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .op_a(op_a[1][15:0]), .op_b(op_b[1][15:0]), .sub(sub[1]), .flush(flush[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .result(r16),
    .cout(cout[1]), .ovf(ovf[1]), .zero(zero[1]));
  cla_seq_adder #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .op_a(op_a[2]), .op_b(op_b[2]), .sub(sub[2]), .flush(flush[2]),
    .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]), .result(r32),
    .cout(cout[2]), .ovf(ovf[2]), .zero(zero[2]));

  function automatic int lw(int l);
    return l == 0 ? 4 : (l == 1 ? 16 : 32);
  endfunction

  // Unsigned and signed arithmetic on the operand values decides every output
  function automatic void calc(input int w, input logic [31:0] a, input logic [31:0] b,
                               input logic s, output logic [31:0] r,
                               output logic c, output logic o, output logic z);
    longint m  = longint'(1) << w;
    longint ua = {32'd0, a} & (m - 1);
    longint ub = {32'd0, b} & (m - 1);
    longint sa = ua >= m / 2 ? ua - m : ua;
    longint sb = ub >= m / 2 ? ub - m : ub;
    longint u  = s ? ua - ub : ua + ub;
    longint sv = s ? sa - sb : sa + sb;
    r = 32'(u & (m - 1));
    c = s ? (ua >= ub) : (u >= m);
    o = (sv >= m / 2) || (sv < -(m / 2));
    z = (u & (m - 1)) == 0;
  endfunction

  task automatic chk(input string nm, input int l, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s lane%0d got %h want %h at %0t", nm, l, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int l = 0; l < 3; l++) begin
      if (!rst_n) begin
        pend[l] = 1'b0;
        chk("rst_req_ready", l, 32'(req_ready[l]), 1);
        chk("rst_resp_valid", l, 32'(resp_valid[l]), 0);
        chk("rst_result", l, res[l], 0);
        chk("rst_flags", l, {29'd0, cout[l], ovf[l], zero[l]}, 0);
      end else begin
        chk("req_ready", l, 32'(req_ready[l]), 32'(!pend[l]));
        chk("resp_valid", l, 32'(resp_valid[l]), 32'(pend[l] && wt[l] == 0));
        if (pend[l] && wt[l] == 0) begin
          chk("result", l, res[l], er[l]);
          chk("cout", l, 32'(cout[l]), 32'(ec[l]));
          chk("ovf", l, 32'(ovf[l]), 32'(eo[l]));
          chk("zero", l, 32'(zero[l]), 32'(ez[l]));
        end
        if (flush[l]) pend[l] = 1'b0;
        else if (!pend[l]) begin
          if (req_valid[l]) begin
            pend[l] = 1'b1;
            wt[l] = lw(l) / 4;
            calc(lw(l), op_a[l], op_b[l], sub[l], er[l], ec[l], eo[l], ez[l]);
          end
        end else if (wt[l] > 0) wt[l]--;
        else if (resp_ready[l]) pend[l] = 1'b0;
      end
    end
  end

  // lat counts cycles from the handshake cycle to the first cycle showing resp_valid
  task automatic op(input int l, input logic [31:0] a, input logic [31:0] b, input logic s,
                    input logic rr, output logic [31:0] r, output logic [2:0] f, output int lat);
    int n = 0;
    @(posedge clk); #1;
    req_valid[l] = 1'b1; op_a[l] = a; op_b[l] = b; sub[l] = s; resp_ready[l] = rr;
    while (!req_ready[l] && n < 100) begin @(posedge clk); #1; n++; end
    chk("accept", l, 32'(req_ready[l]), 1);
    @(posedge clk); #1;
    req_valid[l] = 1'b0; op_a[l] = $urandom; op_b[l] = $urandom; sub[l] = 1'($urandom);
    lat = 1;
    while (!resp_valid[l] && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("resp_seen", l, 32'(resp_valid[l]), 1);
    r = res[l];
    f = {cout[l], ovf[l], zero[l]};
  endtask

  task automatic rnd(input int l, input int nops);
    for (int i = 0; i < nops; i++) begin
      int n = 0;
      @(posedge clk); #1;
      req_valid[l] = 1'b1; op_a[l] = $urandom; op_b[l] = $urandom; sub[l] = 1'($urandom);
      resp_ready[l] = 1'($urandom);
      while (!req_ready[l] && n < 100) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      req_valid[l] = 1'b0;
      n = 0;
      while (!(resp_valid[l] && resp_ready[l]) && n < 300) begin
        @(posedge clk); #1;
        resp_ready[l] = 1'($urandom);
        n++;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic [2:0]  f;
    int          lat;
    for (int l = 0; l < 3; l++) begin op_a[l] = '0; op_b[l] = '0; end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    op(1, 32'h1234, 32'h0FFF, 0, 1, r, f, lat);
    chk("t1_result", 1, r, 32'h2233);
    chk("t1_flags", 1, 32'(f), 3'b000);
    chk("t1_latency", 1, lat, 5);
    op(1, 32'hFFFF, 32'h0001, 0, 1, r, f, lat);
    chk("t2_result", 1, r, 32'h0000);
    chk("t2_flags", 1, 32'(f), 3'b101);
    op(1, 32'h8000, 32'h0001, 1, 1, r, f, lat);
    chk("t3a_result", 1, r, 32'h7FFF);
    chk("t3a_flags", 1, 32'(f), 3'b110);
    op(1, 32'h0003, 32'h0005, 1, 1, r, f, lat);
    chk("t3b_result", 1, r, 32'hFFFE);
    chk("t3b_flags", 1, 32'(f), 3'b000);
    op(0, 32'hF, 32'h1, 0, 1, r, f, lat);
    chk("w4_result", 0, r, 32'h0);
    chk("w4_flags", 0, 32'(f), 3'b101);
    chk("w4_latency", 0, lat, 2);
    op(0, 32'h8, 32'h1, 1, 1, r, f, lat);
    chk("w4_sub_result", 0, r, 32'h7);
    chk("w4_sub_flags", 0, 32'(f), 3'b110);
    op(2, 32'hFFFF_FFFF, 32'h1, 0, 1, r, f, lat);
    chk("w32_result", 2, r, 32'h0);
    chk("w32_flags", 2, 32'(f), 3'b101);
    chk("w32_latency", 2, lat, 9);
    // held response with back-pressure and ignored requests
    op(1, 32'h00F0, 32'h000F, 0, 0, r, f, lat);
    chk("t4_result", 1, r, 32'h00FF);
    for (int k = 0; k < 6; k++) begin
      req_valid[1] = 1'b1; op_a[1] = $urandom; op_b[1] = $urandom;
      @(posedge clk); #1;
      chk("t4_hold", 1, res[1], 32'h00FF);
      chk("t4_ready", 1, 32'(req_ready[1]), 0);
      chk("t4_valid", 1, 32'(resp_valid[1]), 1);
    end
    op_a[1] = 32'd5; op_b[1] = 32'd6; sub[1] = 1'b0; resp_ready[1] = 1'b1;
    @(posedge clk); #1;
    chk("t4_idle", 1, 32'(req_ready[1]), 1);
    chk("t4_drop_valid", 1, 32'(resp_valid[1]), 0);
    @(posedge clk); #1;
    chk("t4_accept", 1, 32'(req_ready[1]), 0);
    req_valid[1] = 1'b0;
    lat = 0;
    while (!resp_valid[1] && lat < 50) begin @(posedge clk); #1; lat++; end
    chk("t4_next", 1, res[1], 32'h000B);
    // async reset in the middle of a run
    @(posedge clk); #1;
    req_valid[1] = 1'b1; op_a[1] = 32'h1234; op_b[1] = 32'h1111; sub[1] = 1'b0;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("t5_ready", 1, 32'(req_ready[1]), 1);
    chk("t5_valid", 1, 32'(resp_valid[1]), 0);
    chk("t5_result", 1, res[1], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    op(1, 32'h0001, 32'h0001, 0, 1, r, f, lat);
    chk("t5_fresh", 1, r, 32'h0002);
    // flush in RUN, in DONE together with resp_ready, and against a request in IDLE
    @(posedge clk); #1;
    req_valid[1] = 1'b1; op_a[1] = 32'h00FF; op_b[1] = 32'h0001;
    @(posedge clk); #1;
    req_valid[1] = 1'b0; flush[1] = 1'b1;
    @(posedge clk); #1;
    flush[1] = 1'b0;
    chk("t6_run_ready", 1, 32'(req_ready[1]), 1);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("t6_run_novalid", 1, 32'(resp_valid[1]), 0);
    end
    op(1, 32'h0101, 32'h0202, 0, 0, r, f, lat);
    flush[1] = 1'b1; resp_ready[1] = 1'b1;
    @(posedge clk); #1;
    flush[1] = 1'b0;
    chk("t6_done_valid", 1, 32'(resp_valid[1]), 0);
    chk("t6_done_ready", 1, 32'(req_ready[1]), 1);
    flush[1] = 1'b1; req_valid[1] = 1'b1;
    @(posedge clk); #1;
    flush[1] = 1'b0; req_valid[1] = 1'b0;
    chk("t6_idle_noaccept", 1, 32'(req_ready[1]), 1);
    fork
      rnd(0, 1000);
      rnd(1, 1000);
      rnd(2, 1000);
    join
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
